// File: rtl/dac_serial_pkg.sv
// Shared constants, format/state encodings and frame-word packing for the
// DAC serial multiplexer.
package dac_serial_pkg;

  localparam int WORD_W = 16;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    FMT_DAC7311  = 2'd0,
    FMT_AD5449_A = 2'd1,
    FMT_AD5449_B = 2'd2,
    FMT_PWRDN    = 2'd3
  } fmt_e;

  localparam logic [3:0] PFX_AD5449_A = 4'h1;
  localparam logic [3:0] PFX_AD5449_B = 4'h4;
  localparam logic [1:0] PFX_PWRDN    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef struct packed {
    fmt_e               fmt;
    logic [DATA_W-1:0]  data;
  } slot_t;

  // Channel index width; a single-channel build still needs a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [WORD_W-1:0] frame_word(input fmt_e fmt,
                                                   input logic [DATA_W-1:0] data);
    logic [WORD_W-1:0] w;
    case (fmt)
      FMT_DAC7311:  w = {2'b00, data, 2'b00};
      FMT_AD5449_A: w = {PFX_AD5449_A, data};
      FMT_AD5449_B: w = {PFX_AD5449_B, data};
      default:      w = {PFX_PWRDN, 14'h0};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dac_serial_mux_if.sv
// Host write port of the DAC serial multiplexer: one strobe carries a
// channel, a 12-bit code and a frame format.
interface dac_serial_mux_if #(parameter int N_CH = 4);
  import dac_serial_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic              wr_strobe;
  logic [CH_W-1:0]   wr_ch;
  logic [DATA_W-1:0] wr_data;
  fmt_e              wr_format;

  modport master (output wr_strobe, wr_ch, wr_data, wr_format);
  modport slave  (input  wr_strobe, wr_ch, wr_data, wr_format);

endinterface

// File: rtl/dac_shift_core.sv
// Frame engine: SETUP/SHIFT/HOLD/GAP sequencing, sclk divider and the
// MSB-first 16-bit shifter.
module dac_shift_core
  import dac_serial_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              ready,
  output logic              frame_end,
  output logic              busy,
  output logic              sclk,
  output logic              sdata
);

  state_e            state, state_nxt;
  logic [7:0]        div_cnt, div_nxt;
  logic [4:0]        hp_cnt, hp_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              sclk_nxt, sdata_nxt;
  logic              div_last, gap_last;

  assign div_last  = (div_cnt == 8'(CLK_DIV - 1));
  assign gap_last  = (div_cnt == 8'(GAP_CYC - 1));
  // Back-to-back frames go straight from the last GAP cycle into SETUP, so
  // sync_n stays high for exactly GAP_CYC cycles between frames.
  assign ready     = (state == ST_IDLE) || ((state == ST_GAP) && gap_last);
  assign frame_end = (state == ST_HOLD) && div_last;
  assign busy      = (state != ST_IDLE);

  // NOTE: every next-state variable gets a default before the case so this
  // block cannot infer a latch; blocking '=' here, '<=' only in always_ff.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt + 8'd1;
    hp_nxt    = hp_cnt;
    shreg_nxt = shreg;
    sclk_nxt  = sclk;
    sdata_nxt = sdata;
    case (state)
      ST_IDLE: begin
        div_nxt = '0;
        if (start) begin
          state_nxt = ST_SETUP;
          shreg_nxt = word;
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_nxt = ST_SHIFT;
          div_nxt   = '0;
          hp_nxt    = '0;
          sclk_nxt  = 1'b1;
          sdata_nxt = shreg[WORD_W-1];
          shreg_nxt = {shreg[WORD_W-2:0], 1'b0};
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_nxt = '0;
          if (hp_cnt == 5'd31) begin
            state_nxt = ST_HOLD;
            sclk_nxt  = 1'b0;
            sdata_nxt = 1'b0;
          end else begin
            hp_nxt   = hp_cnt + 5'd1;
            sclk_nxt = ~sclk;
            // Data moves only on the rising edge; the DAC samples on the fall.
            if (!sclk) begin
              sdata_nxt = shreg[WORD_W-1];
              shreg_nxt = {shreg[WORD_W-2:0], 1'b0};
            end
          end
        end
      end
      ST_HOLD: begin
        if (div_last) begin
          state_nxt = ST_GAP;
          div_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          div_nxt = '0;
          if (start) begin
            state_nxt = ST_SETUP;
            shreg_nxt = word;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      hp_cnt  <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      hp_cnt  <= hp_nxt;
      shreg   <= shreg_nxt;
      sclk    <= sclk_nxt;
      sdata   <= sdata_nxt;
    end
  end

endmodule

// File: rtl/dac_serial_mux.sv
// Multi-channel DAC serializer: per-channel pending store, round-robin
// arbiter and sync_n decode around the shared frame engine.
module dac_serial_mux
  import dac_serial_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CLK_DIV = 1,
  parameter int GAP_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  dac_serial_mux_if.slave     bus,
  output logic                sclk,
  output logic                sdata,
  output logic [N_CH-1:0]     sync_n,
  output logic [N_CH-1:0]     pending,
  output logic                busy,
  output logic                overrun
);

  localparam int CH_W = ch_width(N_CH);

  logic [N_CH-1:0]   valid;
  slot_t             slot_q [N_CH];
  logic [CH_W-1:0]   last_served, grant, cand;
  logic              found, start, ready, frame_end, wr_hit;
  logic [WORD_W-1:0] start_word;

  assign wr_hit     = bus.wr_strobe && (int'(bus.wr_ch) < N_CH);
  assign start      = ready && (|valid);
  assign start_word = frame_word(slot_q[grant].fmt, slot_q[grant].data);
  assign pending    = valid;

  // Round-robin: first valid channel after last_served, wrapping.
  always_comb begin
    grant = last_served;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = CH_W'((int'(last_served) + i) % N_CH);
      if (!found && valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid       <= '0;
      last_served <= CH_W'(N_CH - 1);
      overrun     <= 1'b0;
      sync_n      <= '1;
    end else begin
      overrun <= wr_hit && valid[bus.wr_ch] && !(start && (grant == bus.wr_ch));
      if (start) begin
        valid[grant] <= 1'b0;
        last_served  <= grant;
        sync_n       <= ~(N_CH'(1) << grant);
      end else if (frame_end) begin
        sync_n <= '1;
      end
      // A write landing with its own channel's dispatch re-arms valid: the
      // later assignment wins, and the old value has already been latched.
      if (wr_hit) valid[bus.wr_ch] <= 1'b1;
    end
  end

  // NOTE: the slot storage has no reset; nothing reads a slot unless its
  // valid bit is set, and valid is cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_hit) slot_q[bus.wr_ch] <= '{fmt: bus.wr_format, data: bus.wr_data};
  end

  dac_shift_core #(
    .CLK_DIV (CLK_DIV),
    .GAP_CYC (GAP_CYC)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .word      (start_word),
    .ready     (ready),
    .frame_end (frame_end),
    .busy      (busy),
    .sclk      (sclk),
    .sdata     (sdata)
  );

endmodule

// File: tb/tb_dac_serial_mux.sv
// Bench for dac_serial_mux: a serial-pin monitor rebuilds each frame and
// compares it against a queue of expected frames pushed at write time.
module tb_dac_serial_mux;
  import dac_serial_pkg::*;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] word;
  } exp_t;

  typedef struct {
    logic [1:0]  ch;
    logic [1:0]  fmt;
    logic [11:0] data;
    logic [15:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dac_serial_mux_if #(.N_CH(4)) bus1();
  dac_serial_mux_if #(.N_CH(3)) bus3();

  logic       sclk1, sdata1, busy1, ovr1;
  logic [3:0] sync1, pend1;
  logic       sclk3, sdata3, busy3, ovr3;
  logic [2:0] sync3, pend3;

  dac_serial_mux #(.N_CH(4), .CLK_DIV(1), .GAP_CYC(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .sclk(sclk1), .sdata(sdata1),
    .sync_n(sync1), .pending(pend1), .busy(busy1), .overrun(ovr1)
  );

  dac_serial_mux #(.N_CH(3), .CLK_DIV(3), .GAP_CYC(2)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .sclk(sclk3), .sdata(sdata3),
    .sync_n(sync3), .pending(pend3), .busy(busy3), .overrun(ovr3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  exp_t exp_q[$];
  int   gap_log[$];
  int   frames_pushed = 0;
  int   frames_seen = 0;
  int   ov_cnt = 0;

  bit          m_act[2];
  int          m_len[2], m_bits[2], m_gap[2], m_hi[2];
  logic [15:0] m_word[2];
  logic [3:0]  m_sn[2];
  logic        m_psclk[2], m_psd[2];
  int          div_of[2] = '{1, 3};

  task automatic expect_frame(input logic [1:0] ch, input logic [15:0] word);
    exp_t e;
    e.ch = ch;
    e.word = word;
    exp_q.push_back(e);
    frames_pushed++;
  endtask

  task automatic mon_step(input int id, input logic sck, input logic sd, input logic [3:0] sn);
    exp_t e;
    logic [1:0] ch;
    if (!reset) begin
      m_act[id] = 1'b0;
      m_gap[id] = 0;
      return;
    end
    if (sn != 4'hF) begin
      if (!m_act[id]) begin
        m_act[id] = 1'b1;
        m_len[id] = 0;
        m_bits[id] = 0;
        m_word[id] = '0;
        m_hi[id] = 0;
        m_psclk[id] = 1'b0;
        m_psd[id] = 1'b0;
        m_sn[id] = sn;
        gap_log.push_back(m_gap[id]);
      end
      if (sn != m_sn[id]) check("sync_steady", 32'(sn), 32'(m_sn[id]));
      m_len[id]++;
      if (sck) m_hi[id]++;
      if (m_psclk[id] && !sck) begin
        check("sdata_stable_at_fall", 32'(sd), 32'(m_psd[id]));
        check("sclk_high_len", m_hi[id], div_of[id]);
        m_hi[id] = 0;
        m_word[id] = {m_word[id][14:0], sd};
        m_bits[id]++;
      end
      m_psclk[id] = sck;
      m_psd[id] = sd;
    end else begin
      if (m_act[id]) begin
        m_act[id] = 1'b0;
        frames_seen++;
        ch = '0;
        for (int k = 0; k < 4; k++) if (!m_sn[id][k]) ch = 2'(k);
        check("sync_onehot", $countones(~m_sn[id]), 1);
        check("frame_bits", m_bits[id], 16);
        check("frame_len", m_len[id], 34 * div_of[id]);
        check("frame_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_word", 32'(m_word[id]), 32'(e.word));
          check("frame_ch", 32'(ch), 32'(e.ch));
        end
        m_gap[id] = 0;
      end
      m_gap[id]++;
      if (sck !== 1'b0 || sd !== 1'b0) check("pins_idle", {sck, sd}, 0);
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, sclk1, sdata1, sync1);
    mon_step(1, sclk3, sdata3, {1'b1, sync3});
    if (reset && ovr1 === 1'b1) ov_cnt++;
  end

  task automatic wr1(input logic [1:0] ch, input logic [1:0] fmt, input logic [11:0] data);
    bus1.wr_strobe = 1'b1;
    bus1.wr_ch     = ch;
    bus1.wr_data   = data;
    bus1.wr_format = fmt_e'(fmt);
    @(negedge clk);
    bus1.wr_strobe = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] ch, input logic [1:0] fmt, input logic [11:0] data);
    bus3.wr_strobe = 1'b1;
    bus3.wr_ch     = ch;
    bus3.wr_data   = data;
    bus3.wr_format = fmt_e'(fmt);
    @(negedge clk);
    bus3.wr_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy1 || busy3 || pend1 != 0 || pend3 != 0 || m_act[0] || m_act[1]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({"idle_timeout_", tag}, 32'(n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int seen_before;
    int ov_base;
    logic [3:0] oh, sync_exp;

    vecs[0] = '{2'd2, 2'd0, 12'hABC, 16'h2AF0};
    vecs[1] = '{2'd0, 2'd1, 12'h123, 16'h1123};
    vecs[2] = '{2'd1, 2'd2, 12'h456, 16'h4456};
    vecs[3] = '{2'd3, 2'd3, 12'hFFF, 16'hC000};
    vecs[4] = '{2'd3, 2'd0, 12'hFFF, 16'h3FFC};
    vecs[5] = '{2'd1, 2'd0, 12'h001, 16'h0004};
    vecs[6] = '{2'd0, 2'd1, 12'h000, 16'h1000};
    vecs[7] = '{2'd2, 2'd2, 12'hFFF, 16'h4FFF};

    bus1.wr_strobe = 1'b0; bus1.wr_ch = '0; bus1.wr_data = '0; bus1.wr_format = FMT_DAC7311;
    bus3.wr_strobe = 1'b0; bus3.wr_ch = '0; bus3.wr_data = '0; bus3.wr_format = FMT_DAC7311;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk1), 0);
    check("rst_sdata", 32'(sdata1), 0);
    check("rst_sync", 32'(sync1), 32'hF);
    check("rst_pending", 32'(pend1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_overrun", 32'(ovr1), 0);
    check("rst_sync3", 32'(sync3), 32'h7);
    reset = 1'b1;
    @(negedge clk);

    // Single frames from idle: latency, first rise, busy length
    for (int i = 0; i < 8; i++) begin
      oh = 4'b0001 << vecs[i].ch;
      sync_exp = ~oh;
      expect_frame(vecs[i].ch, vecs[i].word);
      wr1(vecs[i].ch, vecs[i].fmt, vecs[i].data);
      check("pending_after_wr", 32'(pend1), 32'(oh));
      check("busy_before_setup", 32'(busy1), 0);
      check("sync_before_setup", 32'(sync1), 32'hF);
      @(negedge clk);
      check("busy_in_setup", 32'(busy1), 1);
      check("sync_in_setup", 32'(sync1), 32'(sync_exp));
      check("pending_cleared", 32'(pend1), 0);
      check("sclk_in_setup", 32'(sclk1), 0);
      n = 0;
      @(negedge clk);
      n++;
      check("first_rise", 32'(sclk1), 1);
      check("first_bit", 32'(sdata1), 32'(vecs[i].word[15]));
      while (busy1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("busy_len", n, 36);
      wait_idle("vec");
    end

    // Round-robin order with a 2-cycle gap between back-to-back frames
    gap_log.delete();
    expect_frame(2'd0, 16'h0444);
    expect_frame(2'd1, 16'h4456);
    expect_frame(2'd3, 16'h1123);
    wr1(2'd0, 2'd0, 12'h111);
    repeat (5) @(negedge clk);
    wr1(2'd3, 2'd1, 12'h123);
    wr1(2'd1, 2'd2, 12'h456);
    check("rr_pending", 32'(pend1), 32'hA);
    wait_idle("rr");
    check("rr_frames", gap_log.size(), 3);
    check("rr_gap_0_1", gap_log[1], 2);
    check("rr_gap_1_3", gap_log[2], 2);

    // Overwrite before dispatch: one overrun, only the newer value sent
    ov_base = ov_cnt;
    expect_frame(2'd1, 16'h0004);
    expect_frame(2'd0, 16'h0888);
    wr1(2'd1, 2'd0, 12'h001);
    repeat (5) @(negedge clk);
    wr1(2'd0, 2'd0, 12'h111);
    check("no_overrun_first", 32'(ovr1), 0);
    repeat (2) @(negedge clk);
    wr1(2'd0, 2'd0, 12'h222);
    check("overrun_pulse", 32'(ovr1), 1);
    @(negedge clk);
    check("overrun_one_cycle", 32'(ovr1), 0);
    wait_idle("ovr");
    check("overrun_count", ov_cnt - ov_base, 1);

    // Write to the channel currently shifting
    gap_log.delete();
    ov_base = ov_cnt;
    expect_frame(2'd2, 16'h0444);
    expect_frame(2'd2, 16'h0CCC);
    wr1(2'd2, 2'd0, 12'h111);
    repeat (8) @(negedge clk);
    check("self_pending_before", 32'(pend1), 0);
    wr1(2'd2, 2'd0, 12'h333);
    check("self_pending_after", 32'(pend1), 32'h4);
    wait_idle("self");
    check("self_gap", gap_log[1], 2);
    check("self_no_overrun", ov_cnt - ov_base, 0);

    // Write to the channel in its own dispatch cycle
    ov_base = ov_cnt;
    expect_frame(2'd3, 16'h0400);
    expect_frame(2'd3, 16'h0800);
    wr1(2'd3, 2'd0, 12'h100);
    wr1(2'd3, 2'd0, 12'h200);
    check("collide_pending", 32'(pend1), 32'h8);
    check("collide_busy", 32'(busy1), 1);
    wait_idle("collide");
    check("collide_no_overrun", ov_cnt - ov_base, 0);

    // CLK_DIV=3 power-down frame, and an out-of-range channel on N_CH=3
    expect_frame(2'd1, 16'hC000);
    wr3(2'd1, 2'd3, 12'hABC);
    check("div3_pending", 32'(pend3), 32'h2);
    @(negedge clk);
    check("div3_sync", 32'(sync3), 32'h5);
    wait_idle("div3");
    wr3(2'd3, 2'd0, 12'h555);
    check("oor_pending", 32'(pend3), 0);
    @(negedge clk);
    check("oor_busy", 32'(busy3), 0);
    check("oor_sync", 32'(sync3), 32'h7);

    // Reset mid-SHIFT with two channels pending
    wr1(2'd0, 2'd0, 12'h111);
    wr1(2'd1, 2'd0, 12'h222);
    wr1(2'd2, 2'd0, 12'h333);
    check("rst_mid_pending", 32'(pend1), 32'h6);
    n = 0;
    while (!(sclk1 && sdata1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach_high", 32'(n < 40), 1);
    seen_before = frames_seen;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_sclk", 32'(sclk1), 0);
    check("rst_mid_sdata", 32'(sdata1), 0);
    check("rst_mid_sync", 32'(sync1), 32'hF);
    check("rst_mid_pending_clr", 32'(pend1), 0);
    check("rst_mid_busy", 32'(busy1), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (120) @(negedge clk);
    check("rst_no_frame", frames_seen - seen_before, 0);
    check("rst_after_pending", 32'(pend1), 0);
    check("rst_after_busy", 32'(busy1), 0);
    check("rst_after_sync", 32'(sync1), 32'hF);

    check("scoreboard_empty", exp_q.size(), 0);
    check("frames_total", frames_seen, frames_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
